// File: rtl/axi_pkg.sv
// Shared encodings, FSM state type and command legality check for the AXI write-burst generator.
package axi_pkg;

  localparam int STRB_W = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSV   = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_e;

  // A WRAP burst needs a power-of-two beat count and a size-aligned start address.
  function automatic logic cmd_illegal(input logic [2:0] addr_lo, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    logic [2:0] amask;
    amask = (3'd1 << size) - 3'd1;
    if (size > 3'd3) begin
      cmd_illegal = 1'b1;
    end else if (burst == BURST_RSV) begin
      cmd_illegal = 1'b1;
    end else if (burst == BURST_WRAP) begin
      cmd_illegal = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ||
                    ((addr_lo & amask) != 3'd0);
    end else begin
      cmd_illegal = 1'b0;
    end
  endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// Combinational beat address and byte-strobe generator for one beat of an AXI write burst.
module axi_beat_addr
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0]     addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic [7:0]        k,
  output logic [AW-1:0]     addr_k,
  output logic [STRB_W-1:0] wstrb
);

  logic [AW-1:0] step_s;
  logic [AW-1:0] wmask_s;
  logic [AW-1:0] lo_s;
  logic [2:0]    lane_s;
  logic [15:0]   bytes_s;

  // Beat address per burst type, then the active byte lanes of that beat.
  always_comb begin
    step_s  = AW'(k) << size;
    // Legal WRAP containers are a power of two, so the modulo reduces to a mask.
    wmask_s = ((AW'(len) + AW'(1)) << size) - AW'(1);
    lo_s    = addr & ~wmask_s;
    case (burst)
      BURST_FIXED: addr_k = addr;
      BURST_INCR:  addr_k = addr + step_s;
      BURST_WRAP:  addr_k = lo_s + ((addr - lo_s + step_s) & wmask_s);
      default:     addr_k = addr;
    endcase
    lane_s  = addr_k[2:0] & ~((3'd1 << size) - 3'd1);
    bytes_s = (16'd1 << (5'd1 << size)) - 16'd1;
    wstrb   = STRB_W'(bytes_s << lane_s);
  end

endmodule

// File: rtl/axi_wr_burst_gen.sv
// AXI write-burst generator: one command becomes AW, len+1 W beats and a B wait, then done/err.
// Build macro AXI_WGEN_STATS_EN adds the stat_bursts/stat_errs counter outputs.
module axi_wr_burst_gen
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic              axi_aclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [31:0]       cmd_seed,
  output logic [AW-1:0]     awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DW-1:0]     wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              err
`ifdef AXI_WGEN_STATS_EN
  ,
  output logic [15:0]       stat_bursts,
  output logic [15:0]       stat_errs
`endif
);

  state_e              state_q;
  logic                cmd_ready_q;
  logic [AW-1:0]       addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [31:0]         seed_q;
  logic [7:0]          beat_q;
  logic                awvalid_q, wvalid_q, wlast_q, bready_q, done_q, err_q;
  logic [DW-1:0]       wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [1:0]          done_resp_q;

  logic [7:0]          k_d;
  logic [DW-1:0]       wdata_d;
  logic [STRB_W-1:0]   wstrb_s;
  logic [AW-1:0]       beat_addr_unused_s;

  // Index of the beat whose payload is loaded at the next handshake.
  always_comb begin
    if (state_q == ST_AW) begin
      k_d = 8'd0;
    end else begin
      k_d = beat_q + 8'd1;
    end
    wdata_d = {2{seed_q + {24'd0, k_d}}};
  end

  // Only the strobe of the beat address is needed on the W channel.
  axi_beat_addr #(.AW(AW)) u_beat_addr (
    .addr   (addr_q),
    .len    (len_q),
    .size   (size_q),
    .burst  (burst_q),
    .k      (k_d),
    .addr_k (beat_addr_unused_s),
    .wstrb  (wstrb_s)
  );

  // Burst sequencing FSM with all channel outputs registered.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'b00;
      seed_q      <= 32'd0;
      beat_q      <= 8'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      done_resp_q <= RESP_OKAY;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            size_q  <= cmd_size;
            burst_q <= cmd_burst;
            seed_q  <= cmd_seed;
            if (cmd_illegal(cmd_addr[2:0], cmd_len, cmd_size, cmd_burst)) begin
              err_q <= 1'b1;
            end else begin
              awvalid_q   <= 1'b1;
              cmd_ready_q <= 1'b0;
              state_q     <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_s;
            wlast_q   <= (k_d == len_q);
            beat_q    <= k_d;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_q  <= k_d;
              wdata_q <= wdata_d;
              wstrb_q <= wstrb_s;
              wlast_q <= (k_d == len_q);
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            done_q      <= 1'b1;
            done_resp_q <= bresp;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign awaddr    = addr_q;
  assign awlen     = len_q;
  assign awsize    = size_q;
  assign awburst   = burst_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = wlast_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign done      = done_q;
  assign done_resp = done_resp_q;
  assign err       = err_q;

`ifdef AXI_WGEN_STATS_EN
  logic [15:0] stat_bursts_q;
  logic [15:0] stat_errs_q;

  // Counters follow the done/err pulses and wrap naturally at 16 bits.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      stat_bursts_q <= 16'd0;
      stat_errs_q   <= 16'd0;
    end else begin
      if (done_q) begin
        stat_bursts_q <= stat_bursts_q + 16'd1;
      end
      if ((done_q && (done_resp_q != RESP_OKAY)) || err_q) begin
        stat_errs_q <= stat_errs_q + 16'd1;
      end
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_errs   = stat_errs_q;
`else
  // Without the statistics build, completion and errors are visible only on done/err.
`endif

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Self-checking bench for axi_wr_burst_gen: directed table, corner sequences and random bursts vs a model.
module tb_axi_wr_burst_gen;
  import axi_pkg::*;

  logic        axi_aclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [2:0]  cmd_size = 3'd0;
  logic [1:0]  cmd_burst = 2'b00;
  logic [31:0] cmd_seed = 32'd0;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        done;
  logic [1:0]  done_resp;
  logic        err;
`ifdef AXI_WGEN_STATS_EN
  logic [15:0] stat_bursts;
  logic [15:0] stat_errs;
`endif

  axi_wr_burst_gen #(.AW(32), .DW(64)) dut (
    .axi_aclk (axi_aclk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_addr (cmd_addr), .cmd_len (cmd_len),
    .cmd_size (cmd_size), .cmd_burst (cmd_burst), .cmd_seed (cmd_seed),
    .awaddr (awaddr), .awlen (awlen), .awsize (awsize), .awburst (awburst),
    .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready),
    .done (done), .done_resp (done_resp), .err (err)
`ifdef AXI_WGEN_STATS_EN
    , .stat_bursts (stat_bursts), .stat_errs (stat_errs)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_bursts = 0;
  int exp_errs   = 0;

  // Results captured by run_cmd for the table comparisons.
  logic [7:0]  r_strb0, r_strbl;
  logic [63:0] r_data0, r_datal;
  int          r_done_cyc;
  logic        r_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: spec arithmetic on plain integers.
  function automatic bit m_illegal(input logic [31:0] a, input int len, input int size, input logic [1:0] burst);
    if (size > 3) return 1'b1;
    if (burst == BURST_RSV) return 1'b1;
    if (burst == BURST_WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == BURST_WRAP && (a % (32'd1 << size)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input int len, input int size,
                                         input logic [1:0] burst, input int k);
    longint unsigned av, nb, bsz, lo;
    av = 64'(a);
    nb = 64'(1) << size;
    if (burst == BURST_FIXED) return a;
    if (burst == BURST_INCR) return 32'(av + 64'(k) * nb);
    bsz = 64'(len + 1) * nb;
    lo  = (av / bsz) * bsz;
    return 32'(lo + ((av - lo + 64'(k) * nb) % bsz));
  endfunction

  function automatic logic [7:0] m_strb(input logic [31:0] ak, input int size);
    int nb, base;
    logic [7:0] s;
    nb   = 1 << size;
    base = (int'(ak % 32'd8) / nb) * nb;
    s    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i >= base && i < base + nb) s[i] = 1'b1;
    end
    return s;
  endfunction

  task automatic chk_stats();
`ifdef AXI_WGEN_STATS_EN
    check("stat_bursts", 64'(stat_bursts), 64'(16'(exp_bursts)));
    check("stat_errs", 64'(stat_errs), 64'(16'(exp_errs)));
`endif
  endtask

  // Issue one command and follow it to done/err, checking every observed beat against the model.
  task automatic run_cmd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [31:0] seed, input int aw_stall,
                         input int w_mode, input int b_delay, input logic [1:0] resp);
    bit ill, fin, b_on;
    int cyc, beats, aw_hs, aw_wait, b_wait;
    logic [31:0] ak;
    ill = m_illegal(a, int'(len), int'(size), burst);
    @(negedge axi_aclk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; cmd_size = size; cmd_burst = burst; cmd_seed = seed;
    @(negedge axi_aclk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_seed = $urandom;
    r_err = err;
    if (ill) begin
      check("err_pulse", 64'(err), 64'(1));
      check("err_no_aw", 64'(awvalid), 64'(0));
      check("err_cmd_ready", 64'(cmd_ready), 64'(1));
      exp_errs++;
      @(negedge axi_aclk);
      check("err_once", 64'(err), 64'(0));
      check("err_no_aw_later", 64'(awvalid), 64'(0));
      chk_stats();
      return;
    end
    check("no_err", 64'(err), 64'(0));
    cyc = 1; beats = 0; aw_hs = 0; aw_wait = 0; b_wait = 0; b_on = 1'b0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (awvalid) begin
        check("awaddr", 64'(awaddr), 64'(a));
        check("awlen", 64'(awlen), 64'(len));
        check("awsize", 64'(awsize), 64'(size));
        check("awburst", 64'(awburst), 64'(burst));
        awready = (aw_wait >= aw_stall);
        aw_wait++;
        if (awready) aw_hs++;
      end else begin
        awready = 1'($urandom_range(0, 1));
      end
      if (wvalid) begin
        ak = m_addr(a, int'(len), int'(size), burst, beats);
        check("wdata", wdata, {2{seed + 32'(beats)}});
        check("wstrb", 64'(wstrb), 64'(m_strb(ak, int'(size))));
        check("wlast", 64'(wlast), 64'(beats == int'(len)));
        if (beats == 0) begin r_strb0 = wstrb; r_data0 = wdata; end
        r_strbl = wstrb; r_datal = wdata;
        case (w_mode)
          0:       wready = 1'b1;
          1:       wready = 1'(cyc % 2);
          default: wready = 1'($urandom_range(0, 1));
        endcase
        if (wready) beats++;
      end else begin
        wready = 1'($urandom_range(0, 1));
      end
      if (b_on && !done) check("bready_held", 64'(bready), 64'(1));
      if (bready) begin
        b_on   = 1'b1;
        bvalid = (b_wait >= b_delay);
        bresp  = bvalid ? resp : 2'b01;
        b_wait++;
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
      if (done) begin
        fin = 1'b1;
        r_done_cyc = cyc;
        check("done_resp", 64'(done_resp), 64'(resp));
        check("beat_count", 64'(beats), 64'(int'(len) + 1));
        check("aw_handshakes", 64'(aw_hs), 64'(1));
        check("done_wvalid_low", 64'(wvalid), 64'(0));
        exp_bursts++;
        if (resp != RESP_OKAY) exp_errs++;
      end else begin
        @(negedge axi_aclk);
        cyc++;
      end
    end
    check("burst_finished", 64'(fin), 64'(1));
    @(negedge axi_aclk);
    check("done_once", 64'(done), 64'(0));
    check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk_stats();
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] seed;
    logic        ill;
    logic [7:0]  strb0;
    logic [7:0]  strbl;
    logic [63:0] data0;
    logic [63:0] datal;
    logic [7:0]  done_cyc;
  } vec_t;

  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h0000_2002, 8'd2, 3'd1, BURST_INCR, 32'h10, 1'b0, 8'h0C, 8'hC0,
              64'h00000010_00000010, 64'h00000012_00000012, 8'd6};
    vt[1] = '{32'h0000_1008, 8'd3, 3'd3, BURST_WRAP, 32'hA, 1'b0, 8'hFF, 8'hFF,
              64'h0000000A_0000000A, 64'h0000000D_0000000D, 8'd7};
    vt[2] = '{32'h0000_0003, 8'd3, 3'd0, BURST_FIXED, 32'hFFFF_FFFF, 1'b0, 8'h08, 8'h08,
              64'hFFFFFFFF_FFFFFFFF, 64'h00000002_00000002, 8'd7};
    vt[3] = '{32'h0000_0007, 8'd0, 3'd0, BURST_INCR, 32'h5, 1'b0, 8'h80, 8'h80,
              64'h00000005_00000005, 64'h00000005_00000005, 8'd4};
    vt[4] = '{32'h0000_000C, 8'd3, 3'd2, BURST_WRAP, 32'h0, 1'b0, 8'hF0, 8'h0F,
              64'h00000000_00000000, 64'h00000003_00000003, 8'd7};
    vt[5] = '{32'hFFFF_FFFE, 8'd1, 3'd1, BURST_INCR, 32'h7, 1'b0, 8'hC0, 8'h03,
              64'h00000007_00000007, 64'h00000008_00000008, 8'd5};
    vt[6] = '{32'h0000_1000, 8'd2, 3'd3, BURST_WRAP, 32'h1, 1'b1, 8'h0, 8'h0, 64'h0, 64'h0, 8'd0};
    vt[7] = '{32'h0000_1000, 8'd1, 3'd4, BURST_INCR, 32'h1, 1'b1, 8'h0, 8'h0, 64'h0, 64'h0, 8'd0};
    vt[8] = '{32'h0000_1000, 8'd1, 3'd0, BURST_RSV, 32'h1, 1'b1, 8'h0, 8'h0, 64'h0, 64'h0, 8'd0};
    vt[9] = '{32'h0000_1004, 8'd1, 3'd3, BURST_WRAP, 32'h1, 1'b1, 8'h0, 8'h0, 64'h0, 64'h0, 8'd0};

    // Reset state.
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_awvalid", 64'(awvalid), 64'(0));
    check("rst_wvalid", 64'(wvalid), 64'(0));
    check("rst_wlast", 64'(wlast), 64'(0));
    check("rst_bready", 64'(bready), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_done_resp", 64'(done_resp), 64'(0));
    check("rst_awaddr", 64'(awaddr), 64'(0));
    check("rst_awlen", 64'(awlen), 64'(0));
    check("rst_wdata", wdata, 64'(0));
    check("rst_wstrb", 64'(wstrb), 64'(0));
    chk_stats();
    rst = 1'b0;

    // Slow SLVERR response: bready must stay up until bvalid arrives.
    run_cmd(32'h0000_0080, 8'd1, 3'd3, BURST_INCR, 32'h9, 0, 0, 3, RESP_SLVERR);
    check("slverr_done_cyc", 64'(r_done_cyc), 64'(8));
`ifdef AXI_WGEN_STATS_EN
    check("slverr_stat_errs", 64'(stat_errs), 64'(1));
`endif

    // Directed table with all readies high.
    for (int i = 0; i < 10; i++) begin
      run_cmd(vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].seed, 0, 0, 0, RESP_OKAY);
      check("tbl_err", 64'(r_err), 64'(vt[i].ill));
      if (!vt[i].ill) begin
        check("tbl_strb0", 64'(r_strb0), 64'(vt[i].strb0));
        check("tbl_strbl", 64'(r_strbl), 64'(vt[i].strbl));
        check("tbl_data0", r_data0, vt[i].data0);
        check("tbl_datal", r_datal, vt[i].datal);
        check("tbl_done_cyc", 64'(r_done_cyc), 64'(vt[i].done_cyc));
      end
    end

    // Backpressure: AW stalled 5 cycles, wready toggling.
    run_cmd(32'h0000_4000, 8'd4, 3'd2, BURST_INCR, 32'h1234, 5, 1, 0, RESP_OKAY);
    check("bp_done_cyc", 64'(r_done_cyc), 64'(17));

    // Reset during beat 1 of a 4-beat burst abandons it without done.
    @(negedge axi_aclk);
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd3; cmd_size = 3'd3;
    cmd_burst = BURST_INCR; cmd_seed = 32'h55; awready = 1'b1; wready = 1'b1;
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge axi_aclk);
    check("rstb_beat1_data", wdata, {2{32'h56}});
    rst = 1'b1;
    exp_bursts = 0; exp_errs = 0;
    @(negedge axi_aclk);
    check("rstb_wvalid", 64'(wvalid), 64'(0));
    check("rstb_awvalid", 64'(awvalid), 64'(0));
    check("rstb_bready", 64'(bready), 64'(0));
    check("rstb_wlast", 64'(wlast), 64'(0));
    check("rstb_cmd_ready", 64'(cmd_ready), 64'(1));
    rst = 1'b0; bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_aclk);
      check("rstb_no_done", 64'(done), 64'(0));
      check("rstb_no_aw", 64'(awvalid), 64'(0));
    end
    bvalid = 1'b0;
    chk_stats();
    run_cmd(32'h0000_0200, 8'd1, 3'd3, BURST_INCR, 32'h77, 0, 0, 0, RESP_OKAY);
    check("rstb_new_done_cyc", 64'(r_done_cyc), 64'(5));

    // Randomised bursts with random handshakes.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  b;
      logic [2:0]  sz;
      logic [7:0]  ln;
      logic [31:0] ad;
      logic [1:0]  rs;
      b  = 2'($urandom_range(0, 3));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if (b == BURST_WRAP && $urandom_range(0, 3) != 0) ln = 8'((2 << $urandom_range(0, 3)) - 1);
      else ln = 8'($urandom_range(0, 15));
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad = ad & ~32'h7;
      rs = ($urandom_range(0, 1) == 1) ? RESP_SLVERR : RESP_OKAY;
      run_cmd(ad, ln, sz, b, $urandom, $urandom_range(0, 3), 2, $urandom_range(0, 3), rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
